seg7_reader: RTL and testbench

SEG7_READER -- requirements
Module: seg7_reader

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_encode.sv | 31 +++
 rtl/seg7_reader.sv | 164 ++++++++++++++++
 tb/tb_seg7_reader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment bus reader: FSM states, segment
// pattern table, and the digit-enable decoder used by the reader.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Active-high abcdefg patterns; entry n is the glyph for nibble n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,
        7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33,
        7'h79, 7'h6D, 7'h30, 7'h7E
    };

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } digit_sel_t;

    // hit is set only when exactly one enable line is low; idx names that digit.
    function automatic digit_sel_t decode_an(input logic [NUM_DIGITS-1:0] an);
        digit_sel_t r;
        int         zeros;
        r     = '0;
        zeros = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) begin
                zeros = zeros + 1;
                r.idx = i[1:0];
            end
        end
        r.hit = (zeros == 1);
        return r;
    endfunction

endpackage

// File: rtl/seg7_encode.sv
// Inverse of the hex display decoder: maps an active-high abcdefg pattern
// back to its nibble and flags patterns that are not in the glyph table.
module seg7_encode
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output logic       legal
);

    logic [15:0] hit;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_match
            assign hit[gi] = (pattern == SEG_TABLE[gi]);
        end
    endgenerate

    // Table entries are distinct, so at most one hit bit is set.
    always_comb begin
        nibble = '0;
        for (int i = 0; i < 16; i++) begin
            if (hit[i]) begin
                nibble = nibble | 4'(i);
            end
        end
    end

    assign legal = |hit;

endmodule

// File: rtl/seg7_reader.sv
// Recovers a 16-bit value from a multiplexed 4-digit 7-segment bus; a value
// is published only after two consecutive identical complete frames.
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int unsigned SETTLE         = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] value,
    output logic        valid,
    output logic        err
);

    localparam logic [8:0] SETTLE_W = 9'(SETTLE);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  an_lat_q, an_lat_d;
    logic [6:0]  seg_lat_q, seg_lat_d;
    logic [15:0] frame_q, frame_d;
    logic [15:0] prev_frame_q, prev_frame_d;
    logic [3:0]  seen_q, seen_d;
    logic        prev_ok_q, prev_ok_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    digit_sel_t  sel;
    logic [6:0]  seg_eff;
    logic [3:0]  nibble;
    logic        legal;
    logic [15:0] frame_cap;
    logic [3:0]  seen_cap;

    assign sel     = decode_an(an);
    assign seg_eff = SEG_ACTIVE_LOW ? ~seg : seg;

    seg7_encode u_encode (
        .pattern (seg_eff),
        .nibble  (nibble),
        .legal   (legal)
    );

    // A capture only happens while an/seg match the latched copies, so the
    // live bus is what gets decoded and the live an selects the slot.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
            assign frame_cap[4*gi +: 4] = (sel.idx == 2'(gi)) ? nibble : frame_q[4*gi +: 4];
            assign seen_cap[gi]         = seen_q[gi] | (sel.idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        logic       capture;
        logic       changed;
        logic [8:0] cnt_next;

        state_d      = state_q;
        cnt_d        = cnt_q;
        an_lat_d     = an_lat_q;
        seg_lat_d    = seg_lat_q;
        frame_d      = frame_q;
        prev_frame_d = prev_frame_q;
        seen_d       = seen_q;
        prev_ok_d    = prev_ok_q;
        value_d      = value_q;
        valid_d      = 1'b0;
        err_d        = 1'b0;
        capture      = 1'b0;
        changed      = (an != an_lat_q) || (seg != seg_lat_q);
        cnt_next     = {1'b0, cnt_q} + 9'd1;

        case (state_q)
            ST_IDLE: begin
                if (sel.hit) begin
                    cnt_d     = 8'd1;
                    an_lat_d  = an;
                    seg_lat_d = seg;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE, ST_HOLD: begin
                if (!sel.hit) begin
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (changed) begin
                    cnt_d     = 8'd1;
                    an_lat_d  = an;
                    seg_lat_d = seg;
                    state_d   = ST_SETTLE;
                end else if (state_q == ST_SETTLE) begin
                    cnt_d = cnt_next[7:0];
                    if (cnt_next >= SETTLE_W) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase

        if (capture) begin
            if (legal) begin
                frame_d = frame_cap;
                if (seen_cap == 4'hF) begin
                    if (prev_ok_q && (frame_cap == prev_frame_q)) begin
                        value_d = frame_cap;
                        valid_d = 1'b1;
                    end
                    prev_frame_d = frame_cap;
                    prev_ok_d    = 1'b1;
                    seen_d       = 4'h0;
                end else begin
                    seen_d = seen_cap;
                end
            end else begin
                // A garbled digit poisons both the partial and the reference frame.
                err_d     = 1'b1;
                seen_d    = 4'h0;
                prev_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            an_lat_q     <= 4'hF;
            seg_lat_q    <= 7'h00;
            frame_q      <= 16'h0000;
            prev_frame_q <= 16'h0000;
            seen_q       <= 4'h0;
            prev_ok_q    <= 1'b0;
            value_q      <= 16'h0000;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            an_lat_q     <= an_lat_d;
            seg_lat_q    <= seg_lat_d;
            frame_q      <= frame_d;
            prev_frame_q <= prev_frame_d;
            seen_q       <= seen_d;
            prev_ok_q    <= prev_ok_d;
            value_q      <= value_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign value = value_q;
    assign valid = valid_q;
    assign err   = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Directed bench for seg7_reader: frame confirmation, settle filtering,
// illegal glyphs, multi-digit enables and mid-frame reset.
module tb_seg7_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic        valid;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int both_cnt  = 0;

    seg7_reader #(
        .SETTLE         (4),
        .SEG_ACTIVE_LOW (1'b0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .seg   (seg),
        .an    (an),
        .value (value),
        .valid (valid),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (valid) valid_cnt <= valid_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (valid && err) both_cnt <= both_cnt + 1;
    end

    function automatic logic [6:0] enc(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;
            4'h1: return 7'h30;
            4'h2: return 7'h6D;
            4'h3: return 7'h79;
            4'h4: return 7'h33;
            4'h5: return 7'h5B;
            4'h6: return 7'h5F;
            4'h7: return 7'h70;
            4'h8: return 7'h7F;
            4'h9: return 7'h7B;
            4'hA: return 7'h77;
            4'hB: return 7'h1F;
            4'hC: return 7'h4E;
            4'hD: return 7'h3D;
            4'hE: return 7'h4F;
            default: return 7'h47;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
        $display("step an=%b seg=%h cycles=%0d -> value=%h seen=%b valids=%0d errs=%0d",
                 a, s, n, value, dut.seen_q, valid_cnt, err_cnt);
    endtask

    task automatic send_digit(input int d, input logic [3:0] nib);
        logic [3:0] a;
        a = 4'b0001 << d;
        step(~a, enc(nib), 6);
    endtask

    task automatic send_frame(input logic [15:0] v);
        for (int d = 0; d < 4; d++) begin
            send_digit(d, v[4*d +: 4]);
        end
    endtask

    task automatic pulse_reset();
        an    = 4'hF;
        seg   = 7'h00;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_value", 32'(value), 32'h0);
        check("rst_seen", 32'(dut.seen_q), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        an    = 4'hF;
        seg   = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_value", 32'(value), 32'h0);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        check("reset_seen", 32'(dut.seen_q), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Two identical frames confirm 0153; a third repeats the pulse.
        send_frame(16'h0153);
        check("frame1_valids", 32'(valid_cnt), 32'd0);
        check("frame1_value", 32'(value), 32'h0);
        check("frame1_seen", 32'(dut.seen_q), 32'h0);
        send_frame(16'h0153);
        check("frame2_valids", 32'(valid_cnt), 32'd1);
        check("frame2_value", 32'(value), 32'h0153);
        send_frame(16'h0153);
        check("frame3_valids", 32'(valid_cnt), 32'd2);
        check("frame3_value", 32'(value), 32'h0153);

        // Too-short dwell on digit 2, then a stable digit 0.
        step(4'hF, 7'h00, 2);
        step(4'b1011, 7'h7F, 3);
        step(4'b1110, 7'h7E, 6);
        check("short_seen", 32'(dut.seen_q), 32'h1);

        // Illegal glyph on digit 1.
        step(4'b1101, 7'h01, 6);
        check("illegal_err", 32'(err_cnt), 32'd1);
        check("illegal_seen", 32'(dut.seen_q), 32'h0);
        check("illegal_value", 32'(value), 32'h0153);
        check("illegal_valids", 32'(valid_cnt), 32'd2);

        // Two digits enabled at once.
        step(4'b1100, 7'h7E, 6);
        check("multi_state", 32'(dut.state_q), 32'h0);
        check("multi_seen", 32'(dut.seen_q), 32'h0);
        check("multi_err", 32'(err_cnt), 32'd1);

        // Differing frame does not publish; the repeat does.
        pulse_reset();
        send_frame(16'h1234);
        check("f1234_value", 32'(value), 32'h0);
        send_frame(16'h1235);
        check("f1235a_value", 32'(value), 32'h0);
        check("f1235a_valids", 32'(valid_cnt), 32'd2);
        send_frame(16'h1235);
        check("f1235b_value", 32'(value), 32'h1235);
        check("f1235b_valids", 32'(valid_cnt), 32'd3);

        // Reset after three digits discards the partial frame.
        send_digit(0, 4'h3);
        send_digit(1, 4'h5);
        send_digit(2, 4'h1);
        check("partial_seen", 32'(dut.seen_q), 32'h7);
        pulse_reset();
        send_frame(16'h0153);
        check("post_rst1_valids", 32'(valid_cnt), 32'd3);
        check("post_rst1_value", 32'(value), 32'h0);
        send_frame(16'h0153);
        check("post_rst2_valids", 32'(valid_cnt), 32'd4);
        check("post_rst2_value", 32'(value), 32'h0153);

        check("valid_err_overlap", 32'(both_cnt), 32'd0);
        check("total_errs", 32'(err_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
